ldl_p1ram_arb2: RTL and testbench

Two-requester controller for a single-port synchronous RAM, where the RAM has a 1-cycle registered read and `dout` holds its value when `re` is low. The block does three things:
- Initialises every RAM word to a constant after reset and on demand.
- Arbitrates between two requesters with round-robin priority, issuing at most one access per cycle.
- Returns read data to the issuing requester one cycle after the grant.

It sits between client logic and the RAM instance and drives all RAM control ports.

---
 rtl/ldl_p1ram_arb2.sv | 139 +++++++++++++
 tb/tb_ldl_p1ram_arb2.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_p1ram_arb2.sv
// Two-requester round-robin controller for a single-port RAM with a
// 1-cycle registered read; fills the RAM with INIT_VAL after reset or clr.
module ldl_p1ram_arb2 #(
  parameter int              DW       = 8,
  parameter int              DEPTH    = 10,
  parameter int              AW       = $clog2(DEPTH),
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  input  logic          valid_0,
  input  logic          valid_1,
  output logic          ready_0,
  output logic          ready_1,
  input  logic          we_0,
  input  logic          we_1,
  input  logic [AW-1:0] addr_0,
  input  logic [AW-1:0] addr_1,
  input  logic [DW-1:0] wdata_0,
  input  logic [DW-1:0] wdata_1,
  output logic          rvalid_0,
  output logic          rvalid_1,
  output logic [DW-1:0] rdata_0,
  output logic [DW-1:0] rdata_1,
  output logic          ram_re,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    RST,
    INIT,
    RUN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          pri, pri_nx;
  logic          tag_v, tag_v_nx;
  logic          tag_id, tag_id_nx;
  logic          gnt_0, gnt_1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RST;
      cnt    <= '0;
      pri    <= 1'b0;
      tag_v  <= 1'b0;
      tag_id <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pri    <= pri_nx;
      tag_v  <= tag_v_nx;
      tag_id <= tag_id_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    pri_nx    = pri;
    tag_v_nx  = 1'b0;
    tag_id_nx = tag_id;
    gnt_0     = 1'b0;
    gnt_1     = 1'b0;
    busy      = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    unique case (state)
      RST: begin
        busy     = 1'b1;
        state_nx = INIT;
        cnt_nx   = '0;
      end
      INIT: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt;
        ram_din  = INIT_VAL;
        if (clr) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
      RUN: begin
        if (clr) begin
          state_nx = INIT;
          cnt_nx   = '0;
        end else begin
          // pri=0 favours requester 0 on contention
          gnt_0 = valid_0 && (!valid_1 || !pri);
          gnt_1 = valid_1 && (!valid_0 || pri);
          unique case (1'b1)
            gnt_0: begin
              ram_we   = we_0;
              ram_re   = !we_0;
              ram_addr = addr_0;
              ram_din  = we_0 ? wdata_0 : '0;
            end
            gnt_1: begin
              ram_we   = we_1;
              ram_re   = !we_1;
              ram_addr = addr_1;
              ram_din  = we_1 ? wdata_1 : '0;
            end
            default: ;
          endcase
          if (gnt_0 || gnt_1) begin
            pri_nx    = gnt_0;
            tag_v_nx  = ram_re;
            tag_id_nx = gnt_1;
          end
        end
      end
      default: state_nx = RST;
    endcase
  end

  assign ready_0  = gnt_0;
  assign ready_1  = gnt_1;
  assign rvalid_0 = tag_v && !tag_id;
  assign rvalid_1 = tag_v && tag_id;
  assign rdata_0  = ram_dout;
  assign rdata_1  = ram_dout;

endmodule

// File: tb/tb_ldl_p1ram_arb2.sv
// Bench for ldl_p1ram_arb2: RAM model plus a shadow-memory / round-robin
// reference, directed scenarios and randomized two-requester traffic.
module tb_ldl_p1ram_arb2;

  localparam int            DW    = 8;
  localparam int            DEPTH = 10;
  localparam int            AW    = $clog2(DEPTH);
  localparam logic [DW-1:0] IV    = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          busy;
  logic          valid_0 = 1'b0, valid_1 = 1'b0;
  logic          ready_0, ready_1;
  logic          we_0 = 1'b0, we_1 = 1'b0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic          rvalid_0, rvalid_1;
  logic [DW-1:0] rdata_0, rdata_1;
  logic          ram_re, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  int            pri_m;
  int            checks = 0;
  int            errors = 0;

  ldl_p1ram_arb2 #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .INIT_VAL(IV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .valid_0(valid_0), .valid_1(valid_1),
    .ready_0(ready_0), .ready_1(ready_1),
    .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .ram_re(ram_re), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // single-port RAM: registered read, dout holds while re is low
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  function automatic int exp_grant(input logic v0, input logic v1);
    if (v0 && v1) return pri_m;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic note(input int g, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    pri_m = (g == 0) ? 1 : 0;
    if (w) shadow[a] = d;
  endtask

  task automatic fill_shadow();
    for (int i = 0; i < DEPTH; i++) shadow[i] = IV;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    checks++;
    if ({busy, ready_0, ready_1, rvalid_0, rvalid_1, ram_re, ram_we}
          !== 7'b1000000 || ram_addr !== '0 || ram_din !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rdy=%b%b rv=%b%b re=%b we=%b addr=%0d din=%h, want 1 00 00 0 0 0 00",
               busy, ready_0, ready_1, rvalid_0, rvalid_1,
               ram_re, ram_we, ram_addr, ram_din);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== AW'(i)
          || ram_din !== IV || busy !== 1'b1) begin
        errors++;
        $display("FAIL reset_init[%0d]: we=%b re=%b addr=%0d din=%h busy=%b, want 1 0 %0d %h 1",
                 i, ram_we, ram_re, ram_addr, ram_din, busy, i, IV);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_fall: busy=%b, want 0", busy);
    end
    fill_shadow();
    pri_m = 0;
  endtask

  task automatic test_init_readback();
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] e;
      valid_0 = 1'b1;
      we_0    = 1'b0;
      addr_0  = AW'(i);
      #1;
      checks++;
      if (ready_0 !== 1'b1 || ram_re !== 1'b1 || ram_addr !== AW'(i)) begin
        errors++;
        $display("FAIL readback_grant[%0d]: ready_0=%b re=%b addr=%0d, want 1 1 %0d",
                 i, ready_0, ram_re, ram_addr, i);
      end
      e = shadow[i];
      note(0, 1'b0, addr_0, '0);
      tick();
      checks++;
      if (rvalid_0 !== 1'b1 || rvalid_1 !== 1'b0 || rdata_0 !== e) begin
        errors++;
        $display("FAIL readback_data[%0d]: rv=%b%b rdata_0=%h, want rv0=1 rv1=0 %h",
                 i, rvalid_0, rvalid_1, rdata_0, e);
      end
    end
    idle();
  endtask

  task automatic test_single();
    valid_1 = 1'b1;
    we_1    = 1'b1;
    addr_1  = 4'd4;
    wdata_1 = 8'h3C;
    #1;
    checks++;
    if (ready_1 !== 1'b1 || ready_0 !== 1'b0 || ram_we !== 1'b1
        || ram_addr !== 4'd4 || ram_din !== 8'h3C) begin
      errors++;
      $display("FAIL single_write: rdy=%b%b we=%b addr=%0d din=%h, want rdy1=1 we=1 4 3c",
               ready_0, ready_1, ram_we, ram_addr, ram_din);
    end
    note(1, 1'b1, 4'd4, 8'h3C);
    tick();
    we_1 = 1'b0;
    #1;
    checks++;
    if (ready_1 !== 1'b1 || ram_re !== 1'b1) begin
      errors++;
      $display("FAIL single_read_grant: ready_1=%b re=%b, want 1 1",
               ready_1, ram_re);
    end
    note(1, 1'b0, 4'd4, '0);
    tick();
    idle();
    checks++;
    if (rvalid_1 !== 1'b1 || rvalid_0 !== 1'b0 || rdata_1 !== 8'h3C) begin
      errors++;
      $display("FAIL single_read_data: rv=%b%b rdata_1=%h, want rv0=0 rv1=1 3c",
               rvalid_0, rvalid_1, rdata_1);
    end
    tick();
    checks++;
    if (rvalid_1 !== 1'b0 || rvalid_0 !== 1'b0) begin
      errors++;
      $display("FAIL single_rvalid_pulse: rv=%b%b, want 00",
               rvalid_0, rvalid_1);
    end
  endtask

  task automatic test_contention();
    int            order [4] = '{0, 1, 0, 1};
    logic [AW-1:0] a0 [2] = '{4'd0, 4'd2};
    logic [AW-1:0] a1 [2] = '{4'd1, 4'd3};
    int            i0 = 0, i1 = 0;
    // distinct contents; the final requester-1 write leaves pri at 0
    for (int i = 0; i < 5; i++) begin
      logic r1;
      r1 = (i == 4);
      valid_0 = !r1; we_0 = 1'b1; addr_0 = AW'(i); wdata_0 = DW'(8'h10 + i);
      valid_1 = r1;  we_1 = 1'b1; addr_1 = 4'd9;   wdata_1 = 8'h99;
      #1;
      checks++;
      if (ready_0 !== !r1 || ready_1 !== r1) begin
        errors++;
        $display("FAIL contention_setup[%0d]: rdy=%b%b, want %b%b",
                 i, ready_0, ready_1, !r1, r1);
      end
      if (r1) note(1, 1'b1, 4'd9, 8'h99);
      else note(0, 1'b1, AW'(i), DW'(8'h10 + i));
      tick();
    end
    we_0 = 1'b0;
    we_1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      int            g;
      logic [DW-1:0] e;
      valid_0 = (i0 < 2);
      valid_1 = (i1 < 2);
      addr_0  = a0[i0 < 2 ? i0 : 1];
      addr_1  = a1[i1 < 2 ? i1 : 1];
      #1;
      g = exp_grant(valid_0, valid_1);
      checks++;
      if (g != order[c] || ready_0 !== (order[c] == 0)
          || ready_1 !== (order[c] == 1)) begin
        errors++;
        $display("FAIL contention_grant[%0d]: rdy=%b%b model=%0d, want grant %0d",
                 c, ready_0, ready_1, g, order[c]);
      end
      e = shadow[order[c] == 0 ? addr_0 : addr_1];
      note(order[c], 1'b0, '0, '0);
      if (order[c] == 0) i0++;
      else i1++;
      tick();
      checks++;
      if (rvalid_0 !== (order[c] == 0) || rvalid_1 !== (order[c] == 1)
          || (order[c] == 0 ? rdata_0 : rdata_1) !== e) begin
        errors++;
        $display("FAIL contention_data[%0d]: rv=%b%b rdata=%h/%h, want rv for %0d data %h",
                 c, rvalid_0, rvalid_1, rdata_0, rdata_1, order[c], e);
      end
    end
    idle();
  endtask

  task automatic test_clr_traffic();
    logic [DW-1:0] e;
    valid_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd2;
    valid_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd7;
    #1;
    checks++;
    if (pri_m != 0 || ready_0 !== 1'b1 || ready_1 !== 1'b0) begin
      errors++;
      $display("FAIL clr_pre_grant: rdy=%b%b, want 10", ready_0, ready_1);
    end
    e = shadow[2];
    note(0, 1'b0, '0, '0);
    tick();
    addr_0 = 4'd5;
    clr    = 1'b1;
    checks++;
    if (rvalid_0 !== 1'b1 || rdata_0 !== e) begin
      errors++;
      $display("FAIL clr_read_return: rvalid_0=%b rdata_0=%h, want 1 %h",
               rvalid_0, rdata_0, e);
    end
    #1;
    checks++;
    if (ready_0 !== 1'b0 || ready_1 !== 1'b0 || ram_we !== 1'b0
        || ram_re !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_grant: rdy=%b%b we=%b re=%b, want 0000",
               ready_0, ready_1, ram_we, ram_re);
    end
    tick();
    clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_din !== IV
          || busy !== 1'b1 || ready_0 !== 1'b0 || ready_1 !== 1'b0
          || rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin
        errors++;
        $display("FAIL clr_init[%0d]: we=%b addr=%0d din=%h busy=%b rdy=%b%b rv=%b%b, want 1 %0d %h 1 00 00",
                 i, ram_we, ram_addr, ram_din, busy, ready_0, ready_1,
                 rvalid_0, rvalid_1, i, IV);
      end
      if (i == DEPTH - 1) idle();
      tick();
    end
    fill_shadow();
  endtask

  task automatic test_clr_init();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(i) || busy !== 1'b1) begin
        errors++;
        $display("FAIL clr_init_pre[%0d]: we=%b addr=%0d busy=%b, want 1 %0d 1",
                 i, ram_we, ram_addr, busy, i);
      end
      if (i == 6) clr = 1'b1;
      tick();
      clr = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_din !== IV
          || busy !== 1'b1) begin
        errors++;
        $display("FAIL clr_init_restart[%0d]: we=%b addr=%0d din=%h busy=%b, want 1 %0d %h 1",
                 i, ram_we, ram_addr, ram_din, busy, i, IV);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_init_done: busy=%b, want 0", busy);
    end
    fill_shadow();
  endtask

  task automatic test_random();
    logic          rv [2] = '{1'b0, 1'b0};
    logic          rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    for (int c = 0; c < 400; c++) begin
      int            g;
      int            erv;
      logic [DW-1:0] erd;
      for (int r = 0; r < 2; r++) begin
        if (!rv[r]) begin
          rv[r] = ($urandom_range(0, 3) != 0);
          rw[r] = 1'($urandom_range(0, 1));
          ra[r] = AW'($urandom_range(0, DEPTH - 1));
          rd[r] = DW'($urandom);
        end
      end
      valid_0 = rv[0]; we_0 = rw[0]; addr_0 = ra[0]; wdata_0 = rd[0];
      valid_1 = rv[1]; we_1 = rw[1]; addr_1 = ra[1]; wdata_1 = rd[1];
      #1;
      g   = exp_grant(rv[0], rv[1]);
      erv = -1;
      erd = '0;
      checks++;
      if (ready_0 !== (g == 0) || ready_1 !== (g == 1)) begin
        errors++;
        $display("FAIL rand_grant[%0d]: rdy=%b%b, want grant %0d",
                 c, ready_0, ready_1, g);
      end
      checks++;
      if (g < 0) begin
        if (ram_we !== 1'b0 || ram_re !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle_bus[%0d]: we=%b re=%b, want 00",
                   c, ram_we, ram_re);
        end
      end else if (ram_we !== rw[g] || ram_re !== !rw[g]
                   || ram_addr !== ra[g]
                   || (rw[g] && ram_din !== rd[g])) begin
        errors++;
        $display("FAIL rand_bus[%0d]: we=%b re=%b addr=%0d din=%h, want %b %b %0d %h",
                 c, ram_we, ram_re, ram_addr, ram_din,
                 rw[g], !rw[g], ra[g], rd[g]);
      end
      if (g >= 0) begin
        if (!rw[g]) begin
          erv = g;
          erd = shadow[ra[g]];
        end
        note(g, rw[g], ra[g], rd[g]);
        rv[g] = 1'b0;
      end
      tick();
      checks++;
      if (rvalid_0 !== (erv == 0) || rvalid_1 !== (erv == 1)
          || (erv == 0 && rdata_0 !== erd)
          || (erv == 1 && rdata_1 !== erd)) begin
        errors++;
        $display("FAIL rand_resp[%0d]: rv=%b%b rdata=%h/%h, want resp %0d data %h",
                 c, rvalid_0, rvalid_1, rdata_0, rdata_1, erv, erd);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    valid_1 = 1'b1;
    we_1    = 1'b0;
    addr_1  = 4'd3;
    #1;
    checks++;
    if (ready_1 !== (exp_grant(1'b0, 1'b1) == 1) || ram_re !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: ready_1=%b re=%b, want 1 1",
               ready_1, ram_re);
    end
    rst_n = 1'b0;
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0 || ram_we !== 1'b0
          || busy !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_hold[%0d]: rv=%b%b we=%b busy=%b, want 00 0 1",
                 i, rvalid_0, rvalid_1, ram_we, busy);
      end
      tick();
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_din !== IV
          || busy !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_init[%0d]: we=%b addr=%0d din=%h busy=%b, want 1 %0d %h 1",
                 i, ram_we, ram_addr, ram_din, busy, i, IV);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done: busy=%b, want 0", busy);
    end
    fill_shadow();
    pri_m = 0;
  endtask

  initial begin
    test_reset();
    test_init_readback();
    test_single();
    test_contention();
    test_clr_traffic();
    test_clr_init();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
